// File: rtl/wb_fabric_nslv.sv
// Single-master Wishbone fabric: one registered request/response engine fanning the
// management-SoC master out to NUM_SLAVES slaves, with an ack watchdog and sticky error log.
module wb_fabric_nslv #(
    parameter int          NUM_SLAVES  = 4,
    parameter int          SEL_LSB     = 12,
    parameter int          SEL_WD      = 2,
    parameter int          SLV_ADDR_WD = 9,
    parameter int          TIMEOUT_CYC = 255,
    parameter int          TO_WD       = 8,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_ni,
    input  logic                       m_wb_cyc_i,
    input  logic                       m_wb_stb_i,
    input  logic                       m_wb_we_i,
    input  logic [3:0]                 m_wb_sel_i,
    input  logic [31:0]                m_wb_adr_i,
    input  logic [31:0]                m_wb_dat_i,
    output logic [31:0]                m_wb_dat_o,
    output logic                       m_wb_ack_o,
    output logic                       m_wb_err_o,
    output logic [NUM_SLAVES-1:0]      s_wb_cyc_o,
    output logic [NUM_SLAVES-1:0]      s_wb_stb_o,
    output logic                       s_wb_we_o,
    output logic [3:0]                 s_wb_sel_o,
    output logic [SLV_ADDR_WD-1:0]     s_wb_adr_o,
    output logic [31:0]                s_wb_dat_o,
    input  logic [32*NUM_SLAVES-1:0]   s_wb_dat_i,
    input  logic [NUM_SLAVES-1:0]      s_wb_ack_i,
    input  logic                       err_clr_i,
    output logic                       err_irq_o,
    output logic [SEL_WD-1:0]          err_slv_o
);

    // state | meaning
    // IDLE  | waiting for cyc & stb; request fields are captured on acceptance
    // REQ   | selected slave strobed; waits for its ack, the watchdog or a master abort
    //       | (an unmapped index spends one cycle here with no strobe, then errors)
    // RESP  | single-cycle master ack (+err); keeps the held strobe from being re-accepted
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_e;

    localparam logic [TO_WD-1:0] TO_LAST = (TIMEOUT_CYC > 0) ? TO_WD'(TIMEOUT_CYC - 1) : '0;

    state_e                 state_q, state_d;
    logic [SEL_WD-1:0]      idx_q, idx_d;
    logic                   we_q, we_d;
    logic [3:0]             sel_q, sel_d;
    logic [SLV_ADDR_WD-1:0] adr_q, adr_d;
    logic [31:0]            wdat_q, wdat_d;
    logic [31:0]            rdat_q, rdat_d;
    logic                   err_q, err_d;
    logic [TO_WD-1:0]       to_q, to_d;
    logic                   irq_q, irq_d;
    logic [SEL_WD-1:0]      err_slv_q, err_slv_d;

    logic [NUM_SLAVES-1:0]  slv_hot;
    logic                   idx_ok;
    logic                   sel_ack;
    logic [31:0]            sel_rdat;
    logic                   enter_err;
    logic                   unused_adr;

    assign unused_adr = ^m_wb_adr_i;

    always_comb begin
        slv_hot  = '0;
        sel_ack  = 1'b0;
        sel_rdat = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (idx_q == SEL_WD'(k)) begin
                slv_hot[k] = 1'b1;
                sel_ack    = s_wb_ack_i[k];
                sel_rdat   = s_wb_dat_i[32*k +: 32];
            end
        end
        idx_ok = |slv_hot;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        rdat_d    = rdat_q;
        err_d     = 1'b0;
        to_d      = to_q;
        irq_d     = irq_q;
        err_slv_d = err_slv_q;
        enter_err = 1'b0;

        if (err_clr_i) begin
            irq_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (m_wb_cyc_i && m_wb_stb_i) begin
                    idx_d   = m_wb_adr_i[SEL_LSB+SEL_WD-1:SEL_LSB];
                    we_d    = m_wb_we_i;
                    sel_d   = m_wb_sel_i;
                    adr_d   = m_wb_adr_i[SLV_ADDR_WD+1:2];
                    wdat_d  = m_wb_dat_i;
                    to_d    = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                to_d = to_q + TO_WD'(1);
                if (!m_wb_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (!idx_ok) begin
                    state_d   = ST_RESP;
                    enter_err = 1'b1;
                end else if (sel_ack) begin
                    rdat_d  = sel_rdat;
                    state_d = ST_RESP;
                end else if ((TIMEOUT_CYC != 0) && (to_q == TO_LAST)) begin
                    state_d   = ST_RESP;
                    enter_err = 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A new error outranks a coincident clear.
        if (enter_err) begin
            err_d     = 1'b1;
            rdat_d    = ERR_DATA;
            irq_d     = 1'b1;
            err_slv_d = idx_q;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            adr_q     <= '0;
            wdat_q    <= '0;
            rdat_q    <= '0;
            err_q     <= 1'b0;
            to_q      <= '0;
            irq_q     <= 1'b0;
            err_slv_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            rdat_q    <= rdat_d;
            err_q     <= err_d;
            to_q      <= to_d;
            irq_q     <= irq_d;
            err_slv_q <= err_slv_d;
        end
    end

    assign s_wb_cyc_o = (state_q == ST_REQ) ? slv_hot : '0;
    assign s_wb_stb_o = (state_q == ST_REQ) ? slv_hot : '0;
    assign s_wb_we_o  = we_q;
    assign s_wb_sel_o = sel_q;
    assign s_wb_adr_o = adr_q;
    assign s_wb_dat_o = wdat_q;
    assign m_wb_ack_o = (state_q == ST_RESP);
    assign m_wb_err_o = err_q;
    assign m_wb_dat_o = rdat_q;
    assign err_irq_o  = irq_q;
    assign err_slv_o  = err_slv_q;

endmodule
